// File: rtl/fixed_point_display_scan_pkg.sv
// Shared constants and types for the fixed-point 4-digit display scanner:
// active-low gfedcba digit patterns, the slot index type and the value record.
package fixed_point_display_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Slot 3 is the leftmost digit, slot 2 carries the decimal point
  typedef logic [1:0] slot_idx_t;
  localparam slot_idx_t SLOT_LAST = 2'd3;
  localparam slot_idx_t SLOT_DP   = 2'd2;

  // One displayable value: binary integer part plus two raw fraction patterns
  typedef struct packed {
    logic [3:0] intPart;
    logic [6:0] segTenths;
    logic [6:0] segHundredths;
  } disp_val_t;

  localparam disp_val_t DISP_ZERO = '{intPart: 4'd0, segTenths: SEG_0, segHundredths: SEG_0};

endpackage

// File: rtl/fixed_point_display_scan_seg7_encode.sv
// Binary digit to active-low gfedcba pattern; anything above 9 is blanked.
module seg7_encode
  import fixed_point_display_scan_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the digit pattern
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fixed_point_display_scan.sv
// Multiplexed 4-digit scanner for an II.FF fixed-point value.
// New values are staged on load and only copied into the displayed shadow
// at the end of a full frame, so a frame never mixes two values.
// Optional build macro: SCAN_LZ_BLANK_EN blanks the leftmost digit when it is 0.
module fixed_point_display_scan
  import fixed_point_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] int_part,
  input  logic [6:0] seg_tenths,
  input  logic [6:0] seg_hundredths,
  output logic [6:0] seg_out,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic       load_ack
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] divCnt_q, divCnt_d;
  slot_idx_t        idx_q, idx_d;
  disp_val_t        staging_q, staging_d;
  disp_val_t        shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             loadAck_q, loadAck_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;

  disp_val_t        liveVal;
  logic             tick, frameEnd, commit;
  logic             tens;
  logic [3:0]       ones;
  logic [6:0]       tensSeg, onesSeg;

  assign liveVal = '{intPart: int_part, segTenths: seg_tenths, segHundredths: seg_hundredths};

  // Split the shown integer part into a 0/1 tens digit and a 0..9 ones digit
  always_comb begin
    tens = (shadow_q.intPart >= 4'd10);
    ones = shadow_q.intPart - (tens ? 4'd10 : 4'd0);
  end

  seg7_encode u_encTens (.digit_i({3'b000, tens}), .seg_o(tensSeg));
  seg7_encode u_encOnes (.digit_i(ones),            .seg_o(onesSeg));

  // Divider, slot stepping and the stage/commit handshake for new values
  always_comb begin
    tick      = (divCnt_q == CNT_MAX);
    frameEnd  = tick && (idx_q == SLOT_LAST);
    commit    = frameEnd && (pending_q || load);
    divCnt_d  = tick ? '0 : divCnt_q + CNT_W'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    staging_d = load ? liveVal : staging_q;
    shadow_d  = commit ? (load ? liveVal : staging_q) : shadow_q;
    pending_d = commit ? 1'b0 : (load ? 1'b1 : pending_q);
    loadAck_d = commit;
  end

  // Output stage: pick the pattern for the slot currently being driven
  always_comb begin
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: seg_d = shadow_q.segHundredths;
      2'd1: seg_d = shadow_q.segTenths;
      2'd2: seg_d = onesSeg;
      2'd3: begin
`ifdef SCAN_LZ_BLANK_EN
        seg_d = tens ? tensSeg : SEG_BLANK;
`else
        seg_d = tensSeg;
`endif
      end
      default: seg_d = SEG_BLANK;
    endcase
    an_d = ~(4'b0001 << idx_q);
    dp_d = (idx_q != SLOT_DP);
  end

  // State and registered outputs; reset discards anything staged
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt_q  <= '0;
      idx_q     <= '0;
      staging_q <= DISP_ZERO;
      shadow_q  <= DISP_ZERO;
      pending_q <= 1'b0;
      loadAck_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
    end else begin
      divCnt_q  <= divCnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      loadAck_q <= loadAck_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign seg_out  = seg_q;
  assign an_n     = an_q;
  assign dp_n     = dp_q;
  assign load_ack = loadAck_q;

endmodule

// File: tb/tb_fixed_point_display_scan.sv
// Testbench for fixed_point_display_scan with REFRESH_DIV=4 (16-cycle frames).
// Honours SCAN_LZ_BLANK_EN for the expected leftmost-zero pattern.
module tb_fixed_point_display_scan;

   localparam int DIV = 4;

   localparam logic [6:0] P0  = 7'b1000000;
   localparam logic [6:0] P1  = 7'b1111001;
   localparam logic [6:0] P2  = 7'b0100100;
   localparam logic [6:0] P3  = 7'b0110000;
   localparam logic [6:0] P4  = 7'b0011001;
   localparam logic [6:0] P5  = 7'b0010010;
   localparam logic [6:0] P6  = 7'b0000010;
   localparam logic [6:0] P7  = 7'b1111000;
   localparam logic [6:0] P8  = 7'b0000000;
   localparam logic [6:0] P9  = 7'b0010000;
   localparam logic [6:0] BLK = 7'b1111111;
`ifdef SCAN_LZ_BLANK_EN
   localparam logic [6:0] LZ0 = BLK;
`else
   localparam logic [6:0] LZ0 = P0;
`endif

   typedef struct packed {
      logic [3:0] intPart;
      logic [6:0] tenths;
      logic [6:0] hund;
      logic [6:0] s3;
      logic [6:0] s2;
   } vec_t;

   typedef logic [3:0][6:0] frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] intPart;
   logic [6:0] segT;
   logic [6:0] segH;
   logic [6:0] segOut;
   logic       dpN;
   logic [3:0] anN;
   logic       loadAck;

   int     nChecks  = 0;
   int     nFails   = 0;
   int     ackCount = 0;
   int     cyc      = 0;
   frame_t sb[$];
   frame_t shown;
   vec_t   vecs[6];

   fixed_point_display_scan #(.REFRESH_DIV(DIV)) dut (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .int_part      (intPart),
      .seg_tenths    (segT),
      .seg_hundredths(segH),
      .seg_out       (segOut),
      .dp_n          (dpN),
      .an_n          (anN),
      .load_ack      (loadAck)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter since reset release; edge 16k is a frame boundary
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   // Count acknowledge pulses and keep checking that one digit is enabled
   always @(negedge clk) begin
      if (loadAck === 1'b1) ackCount++;
      if (!rst && cyc > 0) checkOutput("anOneHot", $countones(~anN), 1);
   end

   // Global time limit so a stuck run still ends
   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic waitPhase(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((cyc % 16) != p && n < 40);
      if ((cyc % 16) != p) checkOutput("phaseWait", cyc % 16, p);
   endtask

   task automatic applyStimulus(input logic [3:0] ip, input logic [6:0] t, input logic [6:0] h);
      load    = 1'b1;
      intPart = ip;
      segT    = t;
      segH    = h;
      @(negedge clk);
      load    = 1'b0;
   endtask

   task automatic checkFrame(input frame_t f, input string tag);
      logic [3:0] expAn;
      logic       expDp;
      for (int s = 0; s < 4; s++) begin
         waitPhase(1 + 4 * s);
         expAn = ~(4'b0001 << s);
         expDp = (s != 2);
         checkOutput({tag, "_an"}, anN, expAn);
         checkOutput({tag, "_seg"}, segOut, f[s]);
         checkOutput({tag, "_dp"}, dpN, expDp);
         if (s == 0) checkOutput({tag, "_ackSingle"}, loadAck, 1'b0);
      end
   endtask

   task automatic popFrame(output frame_t f);
      checkOutput("sbNotEmpty", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) f = sb.pop_front();
      else f = '0;
   endtask

   initial begin
      frame_t old;
      int     ackBefore;

      vecs[0] = '{4'd12, P6, P2, P1,  P2};
      vecs[1] = '{4'd5,  P3, P7, LZ0, P5};
      vecs[2] = '{4'd15, P0, P8, P1,  P5};
      vecs[3] = '{4'd10, P9, P1, P1,  P0};
      vecs[4] = '{4'd0,  P4, P6, LZ0, P0};
      vecs[5] = '{4'd9,  P5, P9, LZ0, P9};

      rst     = 1'b1;
      load    = 1'b0;
      intPart = 4'd0;
      segT    = BLK;
      segH    = BLK;
      repeat (3) @(negedge clk);

      // Reset state, with a load offered that must be ignored
      checkOutput("rstAn", anN, 4'b1111);
      checkOutput("rstSeg", segOut, BLK);
      checkOutput("rstDp", dpN, 1'b1);
      checkOutput("rstAck", loadAck, 1'b0);
      applyStimulus(4'd8, P8, P8);
      rst   = 1'b0;
      shown = {LZ0, P0, P0, P0};

      // Scan after release: one slot every 4 cycles, wrapping to slot 0
      for (int k = 0; k < 5; k++) begin
         logic [3:0] expAn;
         int         slot;
         slot  = k % 4;
         waitPhase((1 + 4 * k) % 16);
         expAn = ~(4'b0001 << slot);
         checkOutput("scanAn", anN, expAn);
         checkOutput("scanSeg", segOut, shown[slot]);
         checkOutput("scanDp", dpN, (slot != 2));
      end
      checkOutput("noAckAfterRst", ackCount, 0);

      // Table of mid-frame loads
      for (int i = 0; i < 6; i++) begin
         old = shown;
         waitPhase(5);
         applyStimulus(vecs[i].intPart, vecs[i].tenths, vecs[i].hund);
         sb.push_back({vecs[i].s3, vecs[i].s2, vecs[i].tenths, vecs[i].hund});
         waitPhase(9);
         checkOutput("holdSlot2", segOut, old[2]);
         waitPhase(13);
         checkOutput("holdSlot3", segOut, old[3]);
         waitPhase(15);
         checkOutput("ackEarly", loadAck, 1'b0);
         ackBefore = ackCount;
         waitPhase(0);
         checkOutput("ackPulse", loadAck, 1'b1);
         popFrame(shown);
         checkFrame(shown, "vecFrame");
         checkOutput("vecAckCount", ackCount - ackBefore, 1);
      end

      // Two loads in one frame: latest wins, single acknowledge
      ackBefore = ackCount;
      waitPhase(3);
      applyStimulus(4'd3, P1, P4);
      sb.push_back({LZ0, P3, P1, P4});
      waitPhase(7);
      applyStimulus(4'd9, P7, P8);
      void'(sb.pop_back());
      sb.push_back({LZ0, P9, P7, P8});
      waitPhase(15);
      checkOutput("dblNoAck", ackCount - ackBefore, 0);
      waitPhase(0);
      checkOutput("dblAck", loadAck, 1'b1);
      popFrame(shown);
      checkFrame(shown, "dblFrame");
      checkFrame(shown, "dblFrame2");
      checkOutput("dblAckCount", ackCount - ackBefore, 1);

      // Load presented on the boundary cycle itself
      waitPhase(15);
      checkOutput("bndAckIdle", loadAck, 1'b0);
      ackBefore = ackCount;
      applyStimulus(4'd7, P5, P3);
      sb.push_back({LZ0, P7, P5, P3});
      checkOutput("bndAck", loadAck, 1'b1);
      popFrame(shown);
      checkFrame(shown, "bndFrame");
      checkOutput("bndAckCount", ackCount - ackBefore, 1);

      // Load followed by reset before the boundary: value and ack are lost
      waitPhase(5);
      applyStimulus(4'd11, P2, P2);
      sb.push_back({P1, P1, P2, P2});
      ackBefore = ackCount;
      waitPhase(10);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      applyStimulus(4'd8, P8, P8);
      checkOutput("midRstAn", anN, 4'b1111);
      checkOutput("midRstAck", loadAck, 1'b0);
      rst   = 1'b0;
      shown = {LZ0, P0, P0, P0};
      checkFrame(shown, "rstFrame");
      checkFrame(shown, "rstFrame2");
      checkOutput("rstNoAck", ackCount - ackBefore, 0);
      checkOutput("sbDrained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
